// File: rtl/tour_pkg.sv
// Shared definitions for the tour command player and its benches.
// Contents: FSM state encoding, error-code enum, positive-ack byte, Knight
// opcode/heading constants and a helper that packs a Knight move command.
package tour_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_ISSUE     = 3'd1;
  localparam state_t ST_WAIT_SNT  = 3'd2;
  localparam state_t ST_WAIT_RESP = 3'd3;
  localparam state_t ST_NEXT      = 3'd4;
  localparam state_t ST_DONE      = 3'd5;
  localparam state_t ST_ERR       = 3'd6;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NAK     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  localparam logic [7:0] POS_ACK = 8'hA5;

  // Knight command layout: {opcode[3:0], heading[7:0], squares[3:0]}
  localparam logic [3:0]  OP_CAL     = 4'h2;
  localparam logic [3:0]  OP_MOVE    = 4'h4;
  localparam logic [3:0]  OP_MOVE_FF = 4'h5;
  localparam logic [15:0] CAL_GYRO   = 16'h2000;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  function automatic logic [15:0] knight_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                             input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_player_if.sv
// RemoteComm-style command handshake between the player and the UART side.
//   cmd      : command word (player -> RemoteComm)
//   snd_cmd  : one-cycle send strobe (player -> RemoteComm)
//   cmd_snt  : transmission finished (RemoteComm -> player)
//   resp_rdy : one-cycle response valid (RemoteComm -> player)
//   resp     : response byte (RemoteComm -> player)
interface tour_cmd_player_if #(
  parameter int unsigned CMD_W  = 16,
  parameter int unsigned RESP_W = 8
);
  logic [CMD_W-1:0]  cmd;
  logic              snd_cmd;
  logic              cmd_snt;
  logic              resp_rdy;
  logic [RESP_W-1:0] resp;

  modport master (output cmd, output snd_cmd, input cmd_snt, input resp_rdy, input resp);
  modport slave  (input cmd, input snd_cmd, output cmd_snt, output resp_rdy, output resp);
endinterface

// File: rtl/cmd_timeout_cnt.sv
// Clear/enable up-counter that flags expiry after LIMIT enabled cycles.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear to 0 (wins over i_en)
//   i_en       : count enable
//   o_expire   : high while enabled and the count sits at LIMIT-1
module cmd_timeout_cnt #(
  parameter int unsigned LIMIT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  // Saturates at LAST so a late state change cannot wrap past expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);
endmodule

// File: rtl/tour_cmd_player.sv
// Replays a stored list of Knight commands over the RemoteComm handshake,
// checking each response for a positive ack, with per-command timeout,
// bounded retry and abort.
//   clk, rst_n          : clock, async active-low reset
//   i_clr               : empty buffer and clear status (only when not busy)
//   i_wr_en, i_wr_data  : append a command (dropped while busy or full)
//   o_full, o_count     : buffer occupancy
//   i_start, i_abort    : begin playback from slot 0 / stop and go idle
//   rc                  : command/response handshake (master side)
//   o_busy, o_done, o_err, o_err_code, o_cur_idx : playback status
module tour_cmd_player
  import tour_pkg::*;
#(
  parameter int unsigned       DEPTH        = 32,
  parameter int unsigned       CMD_W        = 16,
  parameter int unsigned       RESP_W       = 8,
  parameter logic [RESP_W-1:0] ACK_VAL      = RESP_W'(POS_ACK),
  parameter int unsigned       TIMEOUT_CLKS = 50000000,
  parameter int unsigned       MAX_RETRY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [CMD_W-1:0]         i_wr_data,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_start,
  input  logic                     i_abort,
  tour_cmd_player_if.master        rc,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [1:0]               o_err_code,
  output logic [$clog2(DEPTH)-1:0] o_cur_idx
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  state_t     r_state;
  logic [CMD_W-1:0] r_buf [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [IW-1:0]    r_idx;
  logic [RW-1:0]    r_retry;
  logic             r_done;
  logic             r_err;
  err_code_e        r_err_code;
  logic [CMD_W-1:0] r_cmd;
  logic             r_snd;

  logic          w_idle_like;
  logic          w_busy;
  logic          w_clr_ok;
  logic          w_wr_ok;
  logic          w_last;
  logic          w_expire;
  logic [CW-1:0] w_count_nxt;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_busy      = !w_idle_like;
  assign w_clr_ok    = i_clr && w_idle_like;
  assign w_wr_ok     = i_wr_en && w_idle_like && !r_full && !i_clr;
  assign w_last      = ({1'b0, r_idx} == (r_count - 1'b1));

  always_comb begin
    w_count_nxt = r_count;
    if (w_clr_ok) begin
      w_count_nxt = '0;
    end else if (w_wr_ok) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  cmd_timeout_cnt #(
    .LIMIT (TIMEOUT_CLKS)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state == ST_ISSUE),
    .i_en     ((r_state == ST_WAIT_SNT) || (r_state == ST_WAIT_RESP)),
    .o_expire (w_expire)
  );

  // Command storage carries no reset; an empty count makes its contents moot.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_buf[r_count[IW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_cmd      <= '0;
      r_snd      <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_snd   <= 1'b0;
      if (i_abort && w_busy) begin
        r_state    <= ST_IDLE;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_clr) begin
              r_state    <= ST_IDLE;
              r_done     <= 1'b0;
              r_err      <= 1'b0;
              r_err_code <= ERR_NONE;
              r_idx      <= '0;
            end else if (i_start) begin
              r_done     <= (r_count == '0);
              r_err      <= 1'b0;
              r_err_code <= ERR_NONE;
              r_idx      <= '0;
              r_retry    <= '0;
              r_state    <= (r_count == '0) ? ST_DONE : ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            r_cmd   <= r_buf[r_idx];
            r_snd   <= 1'b1;
            r_state <= ST_WAIT_SNT;
          end
          ST_WAIT_SNT, ST_WAIT_RESP: begin
            // Progress events win over a same-cycle expiry.
            if ((r_state == ST_WAIT_SNT) && rc.cmd_snt) begin
              r_state <= ST_WAIT_RESP;
            end else if ((r_state == ST_WAIT_RESP) && rc.resp_rdy) begin
              if (rc.resp == ACK_VAL) begin
                r_state <= ST_NEXT;
              end else begin
                r_state    <= ST_ERR;
                r_err      <= 1'b1;
                r_err_code <= ERR_NAK;
              end
            end else if (w_expire) begin
              if (r_retry < MAX_RETRY_C) begin
                r_retry <= r_retry + 1'b1;
                r_state <= ST_ISSUE;
              end else begin
                r_state    <= ST_ERR;
                r_err      <= 1'b1;
                r_err_code <= ERR_TIMEOUT;
              end
            end
          end
          ST_NEXT: begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_retry <= '0;
              r_state <= ST_ISSUE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rc.cmd     = r_cmd;
  assign rc.snd_cmd = r_snd;

  assign o_full     = r_full;
  assign o_count    = r_count;
  assign o_busy     = w_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
  assign o_cur_idx  = r_idx;
endmodule

// File: tb/tb_tour_cmd_player.sv
// Self-checking bench for tour_cmd_player: a responder answers each send
// according to a per-send action plan, and a transaction-level model of the
// playback rules predicts the send sequence and final status.
module tb_tour_cmd_player;
  import tour_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 40;
  localparam int unsigned MAXR  = 2;

  localparam int ACT_ACK    = 0;
  localparam int ACT_NAK    = 1;
  localparam int ACT_SILENT = 2;  // never answers
  localparam int ACT_HOLD   = 3;  // cmd_snt only, no response

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        full;
  logic [2:0]  count;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  cur_idx;

  tour_cmd_player_if #(.CMD_W(16), .RESP_W(8)) rc_if ();

  tour_cmd_player #(
    .DEPTH        (DEPTH),
    .CMD_W        (16),
    .RESP_W       (8),
    .ACK_VAL      (8'hA5),
    .TIMEOUT_CLKS (TMO),
    .MAX_RETRY    (MAXR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (clr),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_full     (full),
    .o_count    (count),
    .i_start    (start),
    .i_abort    (abort),
    .rc         (rc_if),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code),
    .o_cur_idx  (cur_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_sent = 0;
  logic [15:0] obs_cmd[$];
  int          obs_cyc[$];
  int          plan[$];
  logic [15:0] mbuf[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int act_at(input int k);
    return (k < plan.size()) ? plan[k] : ACT_SILENT;
  endfunction

  // Responder: records each snd_cmd and answers per the plan.
  initial begin
    int act;
    int d;
    rc_if.cmd_snt  = 1'b0;
    rc_if.resp_rdy = 1'b0;
    rc_if.resp     = '0;
    forever begin
      @(posedge clk); #1;
      if (rc_if.snd_cmd === 1'b1) begin
        obs_cmd.push_back(rc_if.cmd);
        obs_cyc.push_back(cyc);
        act = act_at(n_sent);
        n_sent++;
        if (act != ACT_SILENT) begin
          d = $urandom_range(0, 3);
          for (int i = 0; i < d; i++) begin
            // A response while still waiting for cmd_snt must be ignored.
            rc_if.resp_rdy = (i == 0) && ($urandom_range(0, 1) == 1);
            rc_if.resp     = 8'h3C;
            @(posedge clk); #1;
            rc_if.resp_rdy = 1'b0;
          end
          rc_if.cmd_snt = 1'b1;
          @(posedge clk); #1;
          rc_if.cmd_snt = 1'b0;
          if (act == ACT_ACK || act == ACT_NAK) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            rc_if.resp_rdy = 1'b1;
            rc_if.resp     = 8'hA5;
            if (act == ACT_NAK) begin
              rc_if.resp = 8'($urandom_range(0, 255));
              if (rc_if.resp == 8'hA5) rc_if.resp = 8'h5A;
            end
            @(posedge clk); #1;
            rc_if.resp_rdy = 1'b0;
          end
        end
      end
    end
  end

  task automatic wr_cmd(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (mbuf.size() < DEPTH) mbuf.push_back(d);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    mbuf.delete();
    check_val("clr count", count, 0);
    check_val("clr done", done, 0);
    check_val("clr err", err, 0);
  endtask

  task automatic start_pulse();
    n_sent = 0;
    obs_cmd.delete();
    obs_cyc.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Starts playback, waits for it to finish and compares against the model.
  task automatic run_play(input string tag, input bit wr_busy);
    int pre;
    int i;
    int n;
    int idx;
    int retry;
    int k;
    int act;
    bit e_done;
    bit e_err;
    int e_code;
    logic [15:0] exp_cmd[$];
    pre = mbuf.size();
    start_pulse();
    i = 0;
    while (busy && i < 4000) begin
      wr_en = wr_busy && (i == 1);
      wr_data = 16'hDEAD;
      @(posedge clk); #1;
      i++;
    end
    wr_en = 1'b0;

    n = mbuf.size();
    idx = 0;
    retry = 0;
    k = 0;
    e_done = (n == 0);
    e_err = 1'b0;
    e_code = 0;
    while (!e_done && !e_err) begin
      exp_cmd.push_back(mbuf[idx]);
      act = act_at(k);
      k++;
      if (act == ACT_ACK) begin
        if (idx == n - 1) e_done = 1'b1;
        else begin idx++; retry = 0; end
      end else if (act == ACT_NAK) begin
        e_err = 1'b1;
        e_code = 1;
      end else if (retry < MAXR) begin
        retry++;
      end else begin
        e_err = 1'b1;
        e_code = 2;
      end
    end

    check_val({tag, " idle"}, busy, 0);
    check_val({tag, " count"}, count, pre);
    check_val({tag, " sends"}, obs_cmd.size(), exp_cmd.size());
    for (int j = 0; j < exp_cmd.size() && j < obs_cmd.size(); j++) begin
      check_val($sformatf("%s cmd%0d", tag, j), obs_cmd[j], exp_cmd[j]);
      if (j > 0 && (act_at(j - 1) == ACT_SILENT || act_at(j - 1) == ACT_HOLD))
        check_val($sformatf("%s gap%0d", tag, j), obs_cyc[j] - obs_cyc[j - 1], TMO + 1);
    end
    check_val({tag, " done"}, done, e_done);
    check_val({tag, " err"}, err, e_err);
    check_val({tag, " err_code"}, err_code, e_code);
    check_val({tag, " cur_idx"}, cur_idx, idx);
  endtask

  task automatic wait_first_send(input string tag);
    int i;
    i = 0;
    while (n_sent == 0 && i < 20) begin
      @(posedge clk); #2;
      i++;
    end
    check_val({tag, " first send"}, n_sent, 1);
  endtask

  initial begin
    int n;
    int r;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst busy", busy, 0);
    check_val("rst done", done, 0);
    check_val("rst err", err, 0);
    check_val("rst err_code", err_code, 0);
    check_val("rst cur_idx", cur_idx, 0);
    check_val("rst count", count, 0);
    check_val("rst full", full, 0);
    check_val("rst snd_cmd", rc_if.snd_cmd, 0);
    check_val("rst cmd", rc_if.cmd, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-command tour, all acked; a write during playback is dropped.
    wr_cmd(CAL_GYRO);
    wr_cmd(knight_cmd(OP_MOVE, EAST, 4'd1));
    wr_cmd(knight_cmd(OP_MOVE_FF, SOUTH, 4'd2));
    plan = '{ACT_ACK, ACT_ACK, ACT_ACK};
    run_play("ack3", 1'b1);

    // NAK on the second command.
    do_clr();
    wr_cmd(16'h4BF1);
    wr_cmd(16'h57F2);
    plan = '{ACT_ACK, ACT_NAK};
    run_play("nak", 1'b0);

    // Never answered: initial send plus MAXR retries, then timeout error.
    do_clr();
    wr_cmd(16'h4BF1);
    plan = '{ACT_SILENT, ACT_SILENT, ACT_SILENT};
    run_play("timeout", 1'b0);

    // Overfill: fifth write dropped, only four replayed.
    do_clr();
    for (int i = 0; i < 5; i++) wr_cmd(16'h1000 + 16'(i));
    check_val("fill count", count, DEPTH);
    check_val("fill full", full, 1);
    plan = '{ACT_ACK, ACT_ACK, ACT_ACK, ACT_ACK};
    run_play("full", 1'b0);

    // Abort while waiting for a response.
    do_clr();
    wr_cmd(CAL_GYRO);
    wr_cmd(knight_cmd(OP_MOVE, NORTH, 4'd3));
    plan = '{ACT_HOLD};
    start_pulse();
    wait_first_send("abort");
    repeat (8) @(posedge clk);
    #1;
    check_val("abort pre busy", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort busy", busy, 0);
    check_val("abort done", done, 0);
    check_val("abort err", err, 0);
    rc_if.resp_rdy = 1'b1;
    rc_if.resp = 8'hA5;
    @(posedge clk); #1;
    rc_if.resp_rdy = 1'b0;
    repeat (TMO + 5) @(posedge clk);
    #1;
    check_val("abort sends", n_sent, 1);
    check_val("abort late busy", busy, 0);
    check_val("abort late done", done, 0);
    plan = '{ACT_ACK, ACT_ACK};
    run_play("replay", 1'b0);

    // Empty buffer: straight to done.
    do_clr();
    plan.delete();
    run_play("empty", 1'b0);

    // Randomized tours, sometimes replaying without reloading.
    repeat (25) begin
      if (mbuf.size() == 0 || $urandom_range(0, 1) == 1) begin
        do_clr();
        n = $urandom_range(1, DEPTH + 1);
        for (int i = 0; i < n; i++) wr_cmd(16'($urandom));
        check_val("rnd load count", count, mbuf.size());
        check_val("rnd load full", full, mbuf.size() == DEPTH);
      end
      plan.delete();
      for (int i = 0; i < DEPTH * (MAXR + 1) + 2; i++) begin
        r = $urandom_range(0, 99);
        plan.push_back(r < 70 ? ACT_ACK : r < 78 ? ACT_NAK : r < 89 ? ACT_SILENT : ACT_HOLD);
      end
      run_play("rnd", (mbuf.size() < DEPTH) && ($urandom_range(0, 1) == 1));
    end

    // Reset while waiting for cmd_snt.
    do_clr();
    wr_cmd(16'h4BF1);
    plan = '{ACT_SILENT};
    start_pulse();
    wait_first_send("mid-rst");
    #2 rst_n = 1'b0;
    #1;
    check_val("mid-rst busy", busy, 0);
    check_val("mid-rst done", done, 0);
    check_val("mid-rst err", err, 0);
    check_val("mid-rst err_code", err_code, 0);
    check_val("mid-rst count", count, 0);
    check_val("mid-rst full", full, 0);
    check_val("mid-rst snd_cmd", rc_if.snd_cmd, 0);
    check_val("mid-rst cmd", rc_if.cmd, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mbuf.delete();
    plan.delete();
    @(posedge clk); #1;
    run_play("post-rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tour_cmd_player.md
Name: tour_cmd_player

Overview:
- Synthesizable command sequencer that replays a stored list of 16-bit Knight commands through the RemoteComm-style handshake (snd_cmd/cmd_snt, resp_rdy/resp).
- Successor to the hand-scripted send/ack-check flow: depth, widths, ack value, timeout and retry count are all parameters.
- Adds positive-ack checking, per-command timeout, automatic retry and an abort input.
- Sits between a host/scan loader and RemoteComm; used for bring-up and for multi-move tour regression.

Parameters:
DEPTH, 32, number of command slots (power of 2, ≥2)
CMD_W, 16, command width
RESP_W, 8, response width
ACK_VAL, 8'hA5, response value treated as positive acknowledge
TIMEOUT_CLKS, 50000000, clocks allowed from snd_cmd pulse to resp_rdy
MAX_RETRY, 2, re-sends allowed after a timeout (0 = no retry)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  empty buffer, clear status (honoured only in IDLE/DONE/ERR)
wr_en  in  1  append wr_data to buffer
wr_data  in  CMD_W  command to store
full  out  1  count==DEPTH
count  out  $clog2(DEPTH)+1  commands stored
start  in  1  begin playback from slot 0
abort  in  1  stop playback, return to IDLE
cmd  out  CMD_W  command to RemoteComm
snd_cmd  out  1  one-cycle send strobe
cmd_snt  in  1  RemoteComm finished transmitting
resp_rdy  in  1  response byte valid (one-cycle)
resp  in  RESP_W  response byte
busy  out  1  state not IDLE/DONE/ERR
done  out  1  all commands acked (level, sticky)
err  out  1  playback failed (level, sticky)
err_code  out  2  0 none, 1 NAK, 2 TIMEOUT
cur_idx  out  $clog2(DEPTH)  slot currently/last issued; err index when err=1

Behaviour:
- Clock: clk. Reset: asynchronous, active-low rst_n. Reset values: all outputs 0, cmd=0, state IDLE, buffer count 0; buffer contents don't-care.
- Loading: wr_en accepted only when not busy and not full. Writes while busy or full are dropped; count is unchanged. clr and wr_en in the same cycle: clr wins.
- States:
  - IDLE: start with count==0 → DONE directly. start with count>0 → ISSUE; clear done/err/err_code; cur_idx=0; retry=0.
  - ISSUE: drive cmd=buf[cur_idx] and snd_cmd=1 for exactly one cycle; load timeout counter=0 → WAIT_SNT.
  - WAIT_SNT: on cmd_snt → WAIT_RESP.
  - WAIT_RESP: on resp_rdy, resp==ACK_VAL → NEXT; otherwise → ERR, err_code=1.
  - NEXT: if cur_idx==count-1 → DONE; else cur_idx+1, retry=0 → ISSUE.
  - DONE/ERR: hold status. start → restart as in IDLE; clr → IDLE with status cleared.
- Timeout: counter runs in WAIT_SNT and WAIT_RESP and expires when it reaches TIMEOUT_CLKS-1. On expiry, if retry<MAX_RETRY: retry+1 → ISSUE (same slot). Otherwise → ERR, err_code=2.
- Simultaneous events:
  - resp_rdy in the expiry cycle: the response wins.
  - resp_rdy during WAIT_SNT: ignored.
- cmd holds its value from ISSUE until the next ISSUE (stable for the UART).
- Latency: start → snd_cmd is 2 clocks (IDLE→ISSUE registered, strobe registered).
- abort has priority over everything except reset. In any busy state it goes → IDLE, busy=0, done=0, err=0. The buffer is kept. No further snd_cmd is issued.
- Reset mid-playback: immediate return to reset values; buffer is treated as empty.
- count, full and cur_idx are registered. Arithmetic is unsigned. cur_idx never wraps because playback stops at count-1.

Decomposition:
- Package tour_pkg: state enum (IDLE, ISSUE, WAIT_SNT, WAIT_RESP, NEXT, DONE, ERR), err_code enum (ERR_NONE, ERR_NAK, ERR_TIMEOUT), POS_ACK=8'hA5, and the shared opcode/heading constants (CAL_GYRO, NORTH, EAST, SOUTH, WEST) so benches and RTL use one definition.
- One sub-module, cmd_timeout_cnt: a parametrised clear/enable counter with an expire output.

Test Plan:
- Load 16'h2000, 16'h4BF1, 16'h57F2; start; bench acks each with 8'hA5 → snd_cmd pulses 3 times with cmd in that order, done=1, err=0, cur_idx=2.
- Load 4BF1, 57F2; bench answers the second with 8'h5A → err=1, err_code=1, cur_idx=1, no third snd_cmd.
- TIMEOUT_CLKS=1000, MAX_RETRY=2, bench never sends resp_rdy → 3 snd_cmd pulses ~1000 clocks apart, all with cmd=4BF1, then err_code=2.
- DEPTH=4: write 5 commands → count=4, full=1, 5th dropped. Playback sends only the first 4. Write during busy → count unchanged.
- abort in WAIT_RESP → busy=0 next cycle, done=0, err=0, a later resp_rdy is ignored, re-start replays from slot 0. start with count=0 → done=1, no snd_cmd.
- Deassert rst_n in WAIT_SNT → all outputs 0 asynchronously, count=0, state IDLE.
